// File: rtl/imem_loader.sv
// imem_loader: boot loader that streams bytes into big-endian instruction words,
// writes them to instruction memory and releases the core after a settle delay.
module imem_loader #(
  parameter int ADDR_WIDTH    = 8,
  parameter int START_ADDR    = 0,
  parameter int RELEASE_DELAY = 4
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_n_reset,
  output logic                  load_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   word_count
);
  typedef enum logic [2:0] {LOAD, WRITE, DELAY, DONE, ERROR} state_t;
  localparam int CW = $clog2(RELEASE_DELAY + 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX   = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_START = ADDR_WIDTH'(START_ADDR);
  localparam logic [CW-1:0]         CNT_LAST   = CW'(RELEASE_DELAY - 1);
  state_t                state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  last_q, last_d;
  logic                  we_q, we_d;
  logic                  core_q, core_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  accept;
  assign in_ready = state_q == LOAD;
  assign accept   = in_valid & in_ready;
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= LOAD;
      idx_q   <= '0;
      addr_q  <= ADDR_START;
      wdata_q <= '0;
      cnt_q   <= '0;
      count_q <= '0;
      last_q  <= 1'b0;
      we_q    <= 1'b0;
      core_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      last_q  <= last_d;
      we_q    <= we_d;
      core_q  <= core_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (accept && (idx_q == 2'd3 || in_last)) state_d = WRITE;
      WRITE:   state_d = last_q ? DELAY : (addr_q == ADDR_MAX ? ERROR : LOAD);
      DELAY:   if (cnt_q == CNT_LAST) state_d = DONE;
      default: state_d = state_q;
    endcase
  end
  // Byte 0 clears the word, so a short final word leaves its low bytes zero.
  always_comb begin
    idx_d   = state_q == WRITE ? 2'd0 : (accept ? idx_q + 2'd1 : idx_q);
    wdata_d = !accept ? wdata_q
            : idx_q == 2'd0 ? {in_data, 24'h0}
            : wdata_q | ({in_data, 24'h0} >> {idx_q, 3'b000});
    last_d  = accept ? in_last : last_q;
    addr_d  = (state_q == WRITE && state_d == LOAD) ? addr_q + 1'b1 : addr_q;
    count_d = state_q == WRITE ? count_q + 1'b1 : count_q;
    cnt_d   = state_q == DELAY ? cnt_q + 1'b1 : '0;
  end
  always_comb begin
    we_d   = state_d == WRITE;
    core_d = state_d == DONE;
    done_d = state_d == DONE;
    err_d  = err_q | (accept & in_last & (idx_q != 2'd3)) | (state_d == ERROR);
  end
  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign core_n_reset = core_q;
  assign load_done    = done_q;
  assign load_error   = err_q;
  assign word_count   = count_q;
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the pipelined MIPS core's instruction memory.
- Holds the core in reset and accepts a byte stream over a valid/ready interface.
- Assembles the bytes into 32-bit big-endian instruction words and writes them sequentially into instruction memory.
- After the last word plus a programmable delay, releases the core's reset; the core then fetches from the loaded memory.

Parameters:
- ADDR_WIDTH, 8, instruction-memory word-address width (depth 2^ADDR_WIDTH words).
- START_ADDR, 0, word address of the first written word.
- RELEASE_DELAY, 4, cycles core_n_reset stays low after the final write (minimum 1).

Ports:
- clk  input  1  system clock, rising edge.
- n_reset  input  1  asynchronous active-low reset.
- in_valid  input  1  byte on in_data is valid.
- in_data  input  8  program byte, MSB-first within each word.
- in_last  input  1  marks final byte of the program; qualified by in_valid.
- in_ready  output  1  loader accepts a byte this cycle.
- imem_we  output  1  instruction-memory write enable, one-cycle pulse per word.
- imem_addr  output  ADDR_WIDTH  word address for the write.
- imem_wdata  output  32  word to write.
- core_n_reset  output  1  active-low reset to the core.
- load_done  output  1  program loaded, core released.
- load_error  output  1  sticky error: partial final word or address overflow.
- word_count  output  ADDR_WIDTH+1  number of words written.

Behaviour:
- Reset (async, n_reset low) forces: state LOAD, byte index 0, imem_addr=START_ADDR, word_count=0, imem_we=0, imem_wdata=0, core_n_reset=0, load_done=0, load_error=0.
- in_ready is combinational and equals 1 only in LOAD. A byte is accepted on the rising edge where in_valid & in_ready. in_data and in_last may change only after acceptance; in_valid may drop at any time.
- Byte assembly: byte index k (0..3) loads imem_wdata[31-8k:24-8k].
- States:
  - LOAD: accept bytes. Go to WRITE on acceptance of byte 3, or on acceptance of any byte with in_last=1.
  - WRITE: one cycle, in_ready=0, imem_we=1 with stable addr/data.
    - If in_last was seen → DELAY.
    - Else if imem_addr == 2^ADDR_WIDTH-1 → ERROR.
    - Else → LOAD, with imem_addr+1 and byte index 0.
    - word_count increments on leaving WRITE.
  - DELAY: counter runs RELEASE_DELAY cycles, core_n_reset=0, in_ready=0; then → DONE.
  - DONE: core_n_reset=1, load_done=1, in_ready=0. Terminal until n_reset.
  - ERROR: load_error=1, core_n_reset=0, in_ready=0. Terminal until n_reset.
- Partial final word (in_last on byte index 0..2): the remaining low bytes of imem_wdata are zero. The word is still written, load_error=1, flow continues DELAY→DONE so the core still boots. load_error then coexists with load_done.
- Throughput: 5 cycles per word at best (4 accept + 1 write). Latency from acceptance of the last byte to core_n_reset high = 1 (WRITE) + RELEASE_DELAY cycles.
- imem_addr does not wrap. Overflow goes to ERROR and the core is never released.
- Mid-operation reset: state returns to LOAD and core_n_reset drops immediately (async). Partially assembled words are discarded and memory contents are untouched by the loader.
- All outputs are registered except in_ready.

Test Plan:
- Reset release, in_valid=0 for 20 cycles → in_ready=1, core_n_reset=0, imem_we never 1, word_count=0.
- Stream 20 8C 00 04 then 00 00 00 00 (last on 8th byte), valid every cycle:
  - WRITE1: imem_we pulses at addr 0 with data 0x208C0004.
  - WRITE2: imem_we pulses at addr 1 with 0x00000000.
  - Bytes in the first word's WRITE cycle are held (in_ready=0) and accepted afterwards.
  - core_n_reset rises exactly 1+4 cycles after the 8th byte is accepted; load_done=1; word_count=2.
- Random in_valid gaps (≈50% duty) on the same stream → identical writes and addresses; no byte lost or duplicated.
- 6 bytes AA BB CC DD 11 22, last on 0x22 → second write data 0x11220000, load_error=1, load_done=1 after delay.
- ADDR_WIDTH=2, 5 full words without in_last → writes at addrs 0..3, then ERROR: in_ready=0, load_error=1, core_n_reset stays 0, 5th word never written.
- Assert n_reset low for half a cycle between bytes 2 and 3 of word 0 → immediate core_n_reset=0. After release, a fresh 4-byte stream writes addr 0 with only the new bytes.
